// File: rtl/multi_freq_gen.sv
// Multi-channel 50% duty square-wave generator with per-channel
// shadow/active half-period registers, enables and a common sync.
module multi_freq_gen #(
  parameter int NUM_CH       = 2,
  parameter int SEL_W        = 1,
  parameter int DIV_W        = 16,
  parameter int DEFAULT_HALF = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Enable,
  input  logic              i_Load,
  input  logic [SEL_W-1:0]  i_Ch_Sel,
  input  logic [DIV_W-1:0]  i_Half_Period,
  input  logic              i_Sync,
  output logic [NUM_CH-1:0] o_Freq_Out,
  output logic [NUM_CH-1:0] o_Tick
);

  localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEFAULT_HALF);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow_nxt;
    logic             out_q;
    logic             tick_q;
    logic             load_hit;
    logic             term;

    assign load_hit   = i_Load && (32'(i_Ch_Sel) == n);
    assign shadow_nxt = load_hit ? i_Half_Period : shadow;
    assign term       = (cnt == active);

    // Sync wins over disable and terminal count; a same-cycle load
    // reaches active directly whenever active is being refreshed.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        cnt    <= '0;
        shadow <= HALF_RST;
        active <= HALF_RST;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        shadow <= shadow_nxt;
        if (i_Sync || !i_Enable[n]) begin
          cnt    <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
          active <= shadow_nxt;
        end else if (term) begin
          cnt    <= '0;
          out_q  <= ~out_q;
          tick_q <= ~out_q;
          active <= shadow_nxt;
        end else begin
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b0;
        end
      end
    end

    assign o_Freq_Out[n] = out_q;
    assign o_Tick[n]     = tick_q;
  end

endmodule

// File: tb/tb_multi_freq_gen.sv
// Directed self-checking bench for multi_freq_gen (2 channels,
// SEL_W = 2, DEFAULT_HALF = 1); outputs sampled on falling edges.
module tb_multi_freq_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic        load;
  logic [1:0]  sel;
  logic [15:0] half;
  logic        sync;
  logic [1:0]  fout;
  logic [1:0]  tick;

  int n_cmp;
  int n_bad;
  int e;

  multi_freq_gen #(
    .NUM_CH(2), .SEL_W(2), .DIV_W(16), .DEFAULT_HALF(1)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Enable(en),
    .i_Load(load),
    .i_Ch_Sel(sel),
    .i_Half_Period(half),
    .i_Sync(sync),
    .o_Freq_Out(fout),
    .o_Tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h",
               tag, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  task automatic chk2(input string tag, input logic [1:0] o,
                      input logic [1:0] t);
    chk({tag, "_out"}, 32'(fout), 32'(o));
    chk({tag, "_tick"}, 32'(tick), 32'(t));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    e     = 0;
    rst   = 1'b1;
    en    = 2'b11;
    load  = 1'b0;
    sel   = 2'd0;
    half  = 16'd0;
    sync  = 1'b0;
    step();
    step();
    chk2("rst", 2'b00, 2'b00);
    rst = 1'b0;
    e   = 0;

    // default h=1: period 4, first rise 2 clocks after release
    for (int k = 1; k <= 8; k++) begin
      logic b;
      logic t;
      run_to(k);
      b = (k % 4 == 2) || (k % 4 == 3);
      t = (k % 4 == 2);
      chk2("t1", {b, b}, {t, t});
    end

    // load ch1 h=9 mid-phase
    load = 1'b1; sel = 2'd1; half = 16'd9;
    run_to(9);
    load = 1'b0;
    chk2("t2_e9", 2'b00, 2'b00);
    run_to(10); chk2("t2_e10", 2'b11, 2'b11);
    run_to(19); chk2("t2_e19", 2'b11, 2'b00);
    run_to(20); chk2("t2_e20", 2'b00, 2'b00);
    run_to(29); chk2("t2_e29", 2'b00, 2'b00);
    run_to(30); chk2("t2_e30", 2'b11, 2'b11);

    // load ch0 h=4 on its terminal count: bypass
    run_to(31);
    load = 1'b1; sel = 2'd0; half = 16'd4;
    run_to(32);
    load = 1'b0;
    chk2("t3_e32", 2'b10, 2'b00);
    run_to(36); chk2("t3_e36", 2'b10, 2'b00);
    run_to(37); chk2("t3_e37", 2'b11, 2'b01);
    run_to(42); chk2("t3_e42", 2'b00, 2'b00);

    // ch0 h=2, ch1 h=5, then sync
    load = 1'b1; sel = 2'd0; half = 16'd2;
    run_to(43);
    sel = 2'd1; half = 16'd5;
    run_to(44);
    load = 1'b0; sync = 1'b1;
    run_to(45);
    sync = 1'b0;
    chk2("t4_sync", 2'b00, 2'b00);
    run_to(47); chk2("t4_e47", 2'b00, 2'b00);
    run_to(48); chk2("t4_e48", 2'b01, 2'b01);
    run_to(51); chk2("t4_e51", 2'b10, 2'b10);
    run_to(54); chk2("t4_e54", 2'b11, 2'b01);
    run_to(57); chk2("t4_e57", 2'b00, 2'b00);
    run_to(60); chk2("t4_e60", 2'b01, 2'b01);

    // disable ch0 while high, then re-enable with h=0
    en = 2'b10;
    run_to(61); chk2("t5_dis", 2'b00, 2'b00);
    load = 1'b1; sel = 2'd0; half = 16'd0;
    run_to(62);
    load = 1'b0;
    run_to(63); chk2("t5_e63", 2'b10, 2'b10);
    en = 2'b11;
    run_to(64); chk2("t5_e64", 2'b11, 2'b01);
    run_to(65); chk2("t5_e65", 2'b10, 2'b00);
    run_to(66); chk2("t5_e66", 2'b11, 2'b01);

    // out-of-range channel select is ignored
    load = 1'b1; sel = 2'd3; half = 16'd7;
    run_to(67);
    load = 1'b0;
    chk2("t6_e67", 2'b10, 2'b00);
    run_to(68); chk2("t6_e68", 2'b11, 2'b01);
    run_to(69); chk2("t6_e69", 2'b00, 2'b00);
    run_to(70); chk2("t6_e70", 2'b01, 2'b01);
    run_to(75); chk2("t6_e75", 2'b10, 2'b10);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1 chk2("t6_arst", 2'b00, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
    run_to(1); chk2("t6_r1", 2'b00, 2'b00);
    run_to(2); chk2("t6_r2", 2'b11, 2'b11);
    run_to(3); chk2("t6_r3", 2'b11, 2'b00);
    run_to(4); chk2("t6_r4", 2'b00, 2'b00);
    run_to(6); chk2("t6_r6", 2'b11, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
